rxe_bufctrl: RTL and testbench
==============================

// Module: rxe_bufctrl
//
// PURPOSE
//  Ping-pong receive-buffer scheduler for the Ethernet RX write path.
//  Watches the per-nibble writer's valid/length outputs and gates its memory
//  writes into one of two packet buffers. Commits good packets and drops
//  errored, runt, oversize or no-room packets. Presents committed packets to
//  the CPU side in arrival order until acknowledged.
//
// PARAMETERS
//  AW      12    word-address width of one buffer (buffer = 2^AW 32-bit words)
//  MINLEN  64    minimum committed length, bytes (shorter = runt, discarded)
//  MAXLEN  1518  maximum length, bytes (longer = oversize, dropped)
//
// PORTS
//  i_clk       in   1     system clock
//  i_reset_n   in   1     asynchronous, active-low reset
//  i_wv        in   1     writer valid; high for one packet's write cycles
//  i_len       in   AW+2  writer byte count, valid while i_wv high
//  i_err       in   1     upstream CRC/align error; sampled on the end cycle
//  o_wr_en     out  1     memory write enable (combinational)
//  o_wr_buf    out  1     buffer select bit, concatenated above the word address
//  o_rd_valid  out  1     committed packet waiting at o_rd_buf
//  o_rd_buf    out  1     buffer holding the oldest committed packet
//  o_rd_len    out  AW+2  byte length of that packet
//  i_rd_ack    in   1     single-cycle pulse: CPU done with o_rd_buf
//  i_clr_cnt   in   1     synchronous clear of both counters
//  o_drop_cnt  out  8     saturating count: no-room plus oversize drops
//  o_err_cnt   out  8     saturating count: i_err plus runt discards
//  o_busy      out  1     state != IDLE
//
// BEHAVIOUR
//  Reset (async, i_reset_n low):
//   - state=IDLE; widx=ridx=0; full[1:0]=0; len0=len1=0; counters=0.
//   - Every registered output is 0.
//  States:
//   - IDLE: on i_wv=1, go to RECV if !full[widx], else go to DROP and
//     increment drop_cnt.
//   - RECV: while i_wv=1, latch i_len into len[widx] each cycle.
//   - RECV oversize: if i_wv=1 and i_len>MAXLEN, go to DROP and increment
//     drop_cnt. The buffer stays free.
//   - RECV end: on the first cycle with i_wv=0, the latched length is final.
//     - If i_err or length<MINLEN: increment err_cnt, discard.
//     - Otherwise: set full[widx], toggle widx.
//     - Either way, go to IDLE.
//   - DROP: stay until i_wv=0, then go to IDLE. Never writes; never commits.
//  o_wr_en = i_wv & ((IDLE & !full[widx]) | (RECV & i_len<=MAXLEN)).
//   - Word 0 is therefore written on the start cycle.
//  o_wr_buf = widx (combinational). It is stable for a whole packet.
//  Read side, all combinational:
//   - o_rd_valid = full[ridx]; o_rd_buf = ridx; o_rd_len = len[ridx].
//  i_rd_ack with full[ridx]: clear full[ridx], toggle ridx.
//   - i_rd_ack with !full[ridx] is ignored.
//  Same-cycle commit and ack: both apply (different buffers by construction).
//   - If both buffers were full, the commit slot was reserved at start, so
//     there is no conflict.
//  Counters:
//   - Saturate at 8'hFF.
//   - i_clr_cnt wins over a same-cycle increment.
//  Back-to-back packets: one IDLE cycle (i_wv low) separates packets.
//   - The start check uses full[] as updated by the prior end cycle.
//  i_reset_n assertion mid-packet: the packet is lost. After release, the
//  block waits in IDLE. If i_wv is still high at release, the remainder is
//  treated as a new packet.
//
// TESTING
//  1. 100B good packet into empty block -> o_wr_buf=0 throughout, 25 words
//     written, o_rd_valid=1, o_rd_buf=0, o_rd_len=100.
//  2. Three 80B packets, no ack -> first two commit (bufs 0,1); third sees
//     o_wr_en=0 for all cycles, o_drop_cnt=1. Ack twice -> o_rd_buf 0 then 1,
//     o_rd_valid=0.
//  3. 200B packet, i_err=1 on end cycle -> o_err_cnt=1, o_rd_valid=0, widx
//     unchanged. 40B runt -> o_err_cnt=2.
//  4. 1600B packet -> o_wr_en drops at the i_len=1519 cycle, o_drop_cnt=1,
//     no commit. Next 64B packet -> commits into buf 0, o_rd_len=64.
//  5. i_rd_ack on the same cycle as the end of a good packet into buf 1 ->
//     buf 0 freed, buf 1 committed, o_rd_buf=1, o_rd_len correct.
//  6. Counters at 8'hFF plus a drop -> stay 8'hFF. i_clr_cnt -> 0.
//     i_reset_n pulse mid-RECV -> all outputs 0, o_busy=0.

Source files
------------

// File: rtl/rxe_bufctrl.sv
// rxe_bufctrl: ping-pong receive-buffer scheduler for the Ethernet RX write path.
//
// Watches the per-nibble writer's valid/length outputs and gates its memory
// writes into one of two packet buffers. Good packets are committed, and
// errored, runt, oversize or no-room packets are dropped. Committed packets
// are presented to the CPU side in arrival order until acknowledged.
//
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_wv, i_len       writer valid and running byte count
//   i_err             upstream CRC/align error, sampled on the end cycle
//   o_wr_en, o_wr_buf memory write enable and buffer select (combinational)
//   o_rd_valid, o_rd_buf, o_rd_len
//                     oldest committed packet (combinational from state)
//   i_rd_ack          CPU done with o_rd_buf (single-cycle pulse)
//   i_clr_cnt         synchronous clear of both counters
//   o_drop_cnt        saturating no-room + oversize drop count
//   o_err_cnt         saturating error + runt discard count
//   o_busy            receive FSM not idle
module rxe_bufctrl #(
    parameter int AW     = 12,
    parameter int MINLEN = 64,
    parameter int MAXLEN = 1518
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wv,
    input  logic [AW+1:0] i_len,
    input  logic          i_err,
    output logic          o_wr_en,
    output logic          o_wr_buf,
    output logic          o_rd_valid,
    output logic          o_rd_buf,
    output logic [AW+1:0] o_rd_len,
    input  logic          i_rd_ack,
    input  logic          i_clr_cnt,
    output logic [7:0]    o_drop_cnt,
    output logic [7:0]    o_err_cnt,
    output logic          o_busy
);

    localparam logic [AW+1:0] LP_MINLEN = (AW+2)'(MINLEN);
    localparam logic [AW+1:0] LP_MAXLEN = (AW+2)'(MAXLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_widx;
    logic          r_ridx;
    logic [1:0]    r_full;
    logic [AW+1:0] r_len0;
    logic [AW+1:0] r_len1;
    logic [7:0]    r_drop_cnt;
    logic [7:0]    r_err_cnt;

    logic          w_free;
    logic          w_over;
    logic [AW+1:0] w_cur_len;
    logic          w_end;
    logic          w_commit;
    logic          w_discard;
    logic          w_drop_inc;
    logic          w_ack;
    logic [1:0]    w_full_nxt;

    assign w_free    = ~r_full[r_widx];
    assign w_over    = i_len > LP_MAXLEN;
    assign w_cur_len = r_widx ? r_len1 : r_len0;

    // End cycle: first cycle in RECV with the writer idle; the length latched
    // on the previous cycle is final.
    assign w_end     = (r_state == ST_RECV) & ~i_wv;
    assign w_commit  = w_end & ~i_err & (w_cur_len >= LP_MINLEN);
    assign w_discard = w_end & (i_err | (w_cur_len < LP_MINLEN));

    assign w_drop_inc = i_wv & (((r_state == ST_IDLE) & ~w_free) |
                                ((r_state == ST_RECV) & w_over));
    assign w_ack      = i_rd_ack & r_full[r_ridx];

    assign o_wr_en  = i_wv & (((r_state == ST_IDLE) & w_free) |
                              ((r_state == ST_RECV) & ~w_over));
    assign o_wr_buf = r_widx;

    assign o_rd_valid = r_full[r_ridx];
    assign o_rd_buf   = r_ridx;
    assign o_rd_len   = r_ridx ? r_len1 : r_len0;

    assign o_drop_cnt = r_drop_cnt;
    assign o_err_cnt  = r_err_cnt;
    assign o_busy     = (r_state != ST_IDLE);

    // Commit and ack in the same cycle always target different buffers: the
    // commit target was free at start, while the ack target is full.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit) w_full_nxt[r_widx] = 1'b1;
        if (w_ack)    w_full_nxt[r_ridx] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_widx  <= 1'b0;
            r_ridx  <= 1'b0;
            r_full  <= '0;
            r_len0  <= '0;
            r_len1  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_ack) r_ridx <= ~r_ridx;

            // Length tracks every written word, including the start cycle, so
            // the value seen on the end cycle is the writer's final count.
            if (o_wr_en) begin
                if (r_widx) r_len1 <= i_len;
                else        r_len0 <= i_len;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_wv) r_state <= w_free ? ST_RECV : ST_DROP;
                end
                ST_RECV: begin
                    if (i_wv) begin
                        if (w_over) r_state <= ST_DROP;
                    end else begin
                        r_state <= ST_IDLE;
                        if (w_commit) r_widx <= ~r_widx;
                    end
                end
                ST_DROP: begin
                    if (!i_wv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (i_clr_cnt) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_discard  && (r_err_cnt  != 8'hFF)) r_err_cnt  <= r_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rxe_bufctrl.sv
module tb_rxe_bufctrl;

    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic          wv;
    logic [AW+1:0] len;
    logic          err;
    logic          wr_en;
    logic          wr_buf;
    logic          rd_valid;
    logic          rd_buf;
    logic [AW+1:0] rd_len;
    logic          rd_ack;
    logic          clr_cnt;
    logic [7:0]    drop_cnt;
    logic [7:0]    err_cnt;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;

    rxe_bufctrl #(.AW(AW), .MINLEN(64), .MAXLEN(1518)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_wv       (wv),
        .i_len      (len),
        .i_err      (err),
        .o_wr_en    (wr_en),
        .o_wr_buf   (wr_buf),
        .o_rd_valid (rd_valid),
        .o_rd_buf   (rd_buf),
        .o_rd_len   (rd_len),
        .i_rd_ack   (rd_ack),
        .i_clr_cnt  (clr_cnt),
        .o_drop_cnt (drop_cnt),
        .o_err_cnt  (err_cnt),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One cycle per table row: inputs applied after the edge, outputs sampled
    // 1ns later, before the next edge.
    typedef struct {
        logic wv;
        int   len;
        logic err;
        logic ack;
        logic clr;
        logic x_wr_en;
        logic x_wr_buf;
        logic x_rd_valid;
        logic x_rd_buf;
        int   x_rd_len;
        int   x_drop;
        int   x_err;
        logic x_busy;
    } vec_t;

    vec_t vecs[20];

    // Drive a packet of 'bytes' with length stepping by 'step' per cycle, then
    // one end cycle (wv low) carrying err/ack. Returns writes seen, cycles where
    // wr_buf differed from exp_buf, and the first length at which wr_en fell.
    task automatic send_pkt(input int bytes, input int step, input logic e,
                            input logic ack_end, input logic exp_buf,
                            output int writes, output int bufbad,
                            output int off_len);
        int n;
        writes  = 0;
        bufbad  = 0;
        off_len = -1;
        n = (bytes + step - 1) / step;
        for (int k = 1; k <= n; k++) begin
            wv  = 1'b1;
            len = (AW+2)'((k * step > bytes) ? bytes : k * step);
            #1;
            if (wr_en) writes++;
            else if (off_len < 0) off_len = int'(len);
            if (wr_buf != exp_buf) bufbad++;
            @(posedge clk); #1;
        end
        wv     = 1'b0;
        err    = e;
        rd_ack = ack_end;
        #1;
        if (wr_en) writes++;
        @(posedge clk); #1;
        err    = 1'b0;
        rd_ack = 1'b0;
    endtask

    task automatic ack_once;
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        #1;
    endtask

    task automatic do_reset;
        wv = 1'b0; err = 1'b0; rd_ack = 1'b0; clr_cnt = 1'b0; len = '0;
        rst_n = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w, bb, ol;

        //           wv  len   err ack clr  wr_en buf rdv rdb rdlen drop err busy
        vecs[0]  = '{1, 32,   0,  0,  0,   1,    0,  0,  0,  0,    0,   0,  0};
        vecs[1]  = '{1, 64,   0,  0,  0,   1,    0,  0,  0,  0,    0,   0,  1};
        vecs[2]  = '{1, 96,   0,  0,  0,   1,    0,  0,  0,  0,    0,   0,  1};
        vecs[3]  = '{0, 96,   0,  0,  0,   0,    0,  0,  0,  0,    0,   0,  1};
        vecs[4]  = '{0, 96,   0,  0,  0,   0,    1,  1,  0,  96,   0,   0,  0};
        vecs[5]  = '{1, 40,   0,  0,  0,   1,    1,  1,  0,  96,   0,   0,  0};
        vecs[6]  = '{0, 40,   0,  0,  0,   0,    1,  1,  0,  96,   0,   0,  1};
        vecs[7]  = '{0, 40,   0,  0,  0,   0,    1,  1,  0,  96,   0,   1,  0};
        vecs[8]  = '{1, 1500, 0,  0,  0,   1,    1,  1,  0,  96,   0,   1,  0};
        vecs[9]  = '{1, 1519, 0,  0,  0,   0,    1,  1,  0,  96,   0,   1,  1};
        vecs[10] = '{1, 1600, 0,  0,  0,   0,    1,  1,  0,  96,   1,   1,  1};
        vecs[11] = '{0, 1600, 0,  0,  0,   0,    1,  1,  0,  96,   1,   1,  1};
        vecs[12] = '{0, 0,    0,  1,  0,   0,    1,  1,  0,  96,   1,   1,  0};
        vecs[13] = '{0, 0,    0,  0,  0,   0,    1,  0,  1,  0,    1,   1,  0};
        vecs[14] = '{1, 100,  0,  0,  0,   1,    1,  0,  1,  0,    1,   1,  0};
        vecs[15] = '{1, 200,  0,  0,  0,   1,    1,  0,  1,  0,    1,   1,  1};
        vecs[16] = '{0, 200,  1,  0,  0,   0,    1,  0,  1,  0,    1,   1,  1};
        vecs[17] = '{0, 0,    0,  0,  0,   0,    1,  0,  1,  0,    1,   2,  0};
        vecs[18] = '{0, 0,    0,  0,  1,   0,    1,  0,  1,  0,    1,   2,  0};
        vecs[19] = '{0, 0,    0,  0,  0,   0,    1,  0,  1,  0,    0,   0,  0};

        // Reset state
        wv = 1'b0; err = 1'b0; rd_ack = 1'b0; clr_cnt = 1'b0; len = '0;
        rst_n = 1'b0;
        #12;
        chk("rst wr_en",    int'(wr_en),    0);
        chk("rst wr_buf",   int'(wr_buf),   0);
        chk("rst rd_valid", int'(rd_valid), 0);
        chk("rst rd_buf",   int'(rd_buf),   0);
        chk("rst rd_len",   int'(rd_len),   0);
        chk("rst drop_cnt", int'(drop_cnt), 0);
        chk("rst err_cnt",  int'(err_cnt),  0);
        chk("rst busy",     int'(busy),     0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven cycle vectors
        for (int i = 0; i < 20; i++) begin
            wv      = vecs[i].wv;
            len     = (AW+2)'(vecs[i].len);
            err     = vecs[i].err;
            rd_ack  = vecs[i].ack;
            clr_cnt = vecs[i].clr;
            #1;
            chk($sformatf("v%0d wr_en", i),    int'(wr_en),    int'(vecs[i].x_wr_en));
            chk($sformatf("v%0d wr_buf", i),   int'(wr_buf),   int'(vecs[i].x_wr_buf));
            chk($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(vecs[i].x_rd_valid));
            chk($sformatf("v%0d rd_buf", i),   int'(rd_buf),   int'(vecs[i].x_rd_buf));
            if (vecs[i].x_rd_valid)
                chk($sformatf("v%0d rd_len", i), int'(rd_len), vecs[i].x_rd_len);
            chk($sformatf("v%0d drop_cnt", i), int'(drop_cnt), vecs[i].x_drop);
            chk($sformatf("v%0d err_cnt", i),  int'(err_cnt),  vecs[i].x_err);
            chk($sformatf("v%0d busy", i),     int'(busy),     int'(vecs[i].x_busy));
            @(posedge clk); #1;
        end
        wv = 1'b0; err = 1'b0; rd_ack = 1'b0; clr_cnt = 1'b0;

        // 100B good packet into an empty block
        do_reset();
        send_pkt(100, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t1 writes",   w, 25);
        chk("t1 bufbad",   bb, 0);
        chk("t1 rd_valid", int'(rd_valid), 1);
        chk("t1 rd_buf",   int'(rd_buf), 0);
        chk("t1 rd_len",   int'(rd_len), 100);

        // Three 80B packets without ack: third has no room
        do_reset();
        send_pkt(80, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        chk("t2 p0 writes", w, 20);
        send_pkt(80, 4, 1'b0, 1'b0, 1'b1, w, bb, ol);
        chk("t2 p1 writes", w, 20);
        chk("t2 p1 bufbad", bb, 0);
        send_pkt(80, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t2 p2 writes", w, 0);
        chk("t2 drop_cnt",  int'(drop_cnt), 1);
        chk("t2 rd_buf a",  int'(rd_buf), 0);
        chk("t2 rd_len a",  int'(rd_len), 80);
        ack_once();
        chk("t2 rd_valid b", int'(rd_valid), 1);
        chk("t2 rd_buf b",   int'(rd_buf), 1);
        ack_once();
        chk("t2 rd_valid c", int'(rd_valid), 0);
        ack_once();
        chk("t2 ignored ack", int'(rd_buf), 0);

        // Errored 200B packet, then a 40B runt
        do_reset();
        send_pkt(200, 4, 1'b1, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t3 err_cnt a",  int'(err_cnt), 1);
        chk("t3 rd_valid",   int'(rd_valid), 0);
        chk("t3 wr_buf",     int'(wr_buf), 0);
        send_pkt(40, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t3 err_cnt b",  int'(err_cnt), 2);
        chk("t3 wr_buf b",   int'(wr_buf), 0);

        // Oversize 1600B packet, then a minimum-length good packet
        do_reset();
        send_pkt(1600, 1, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t4 off_len",   ol, 1519);
        chk("t4 writes",    w, 1518);
        chk("t4 drop_cnt",  int'(drop_cnt), 1);
        chk("t4 rd_valid",  int'(rd_valid), 0);
        send_pkt(64, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t4 rd_valid b", int'(rd_valid), 1);
        chk("t4 rd_buf b",   int'(rd_buf), 0);
        chk("t4 rd_len b",   int'(rd_len), 64);
        chk("t4 wr_buf b",   int'(wr_buf), 1);

        // Ack on the same cycle as a commit into buffer 1
        do_reset();
        send_pkt(80, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        send_pkt(120, 4, 1'b0, 1'b1, 1'b1, w, bb, ol);
        #1;
        chk("t5 rd_valid", int'(rd_valid), 1);
        chk("t5 rd_buf",   int'(rd_buf), 1);
        chk("t5 rd_len",   int'(rd_len), 120);
        chk("t5 wr_buf",   int'(wr_buf), 0);
        send_pkt(68, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        chk("t5 buf0 reuse", w, 17);

        // Drop counter saturation and clear priority
        do_reset();
        send_pkt(80, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        send_pkt(80, 4, 1'b0, 1'b0, 1'b1, w, bb, ol);
        for (int d = 0; d < 260; d++) send_pkt(4, 4, 1'b0, 1'b0, 1'b0, w, bb, ol);
        #1;
        chk("t6 drop sat", int'(drop_cnt), 255);
        wv      = 1'b1;
        len     = 14'd4;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        wv      = 1'b0;
        #1;
        chk("t6 clr wins", int'(drop_cnt), 0);
        @(posedge clk); #1;

        // Reset pulse mid-RECV
        ack_once();
        ack_once();
        wv  = 1'b1;
        len = 14'd8;
        @(posedge clk); #1;
        len = 14'd16;
        @(posedge clk); #1;
        chk("t6 busy pre", int'(busy), 1);
        wv    = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t6 rst busy",     int'(busy), 0);
        chk("t6 rst wr_en",    int'(wr_en), 0);
        chk("t6 rst wr_buf",   int'(wr_buf), 0);
        chk("t6 rst rd_valid", int'(rd_valid), 0);
        chk("t6 rst rd_len",   int'(rd_len), 0);
        chk("t6 rst err_cnt",  int'(err_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wv    = 1'b1;
        len   = 14'd4;
        #1;
        chk("t6 restart wr_en", int'(wr_en), 1);
        @(posedge clk); #1;
        wv = 1'b0;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
